// File: rtl/apb_bus_arbiter.sv
// Two-requester arbiter in front of the APB master's internal transfer interface.
// Launches one request at a time and tracks the master's IDLE->SETUP->ACCESS sequence.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrate and launch (m_transfer pulse)
// SETUP  | master in its SETUP cycle; request fields held
// ACCESS | waiting for m_ready; m_rdata captured on completion
// DONE   | one-cycle done pulse to the granted requester
module apb_bus_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        m_transfer,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;  // 0 = requester 0, 1 = requester 1
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        pick1;

  always_comb begin
    if (req0_valid && req1_valid) begin
      pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick1 = req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    m_transfer   = 1'b0;
    m_write      = write_q;
    m_addr       = addr_q;
    m_wdata      = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // Launch is suppressed while PRESET is high so outputs read as reset values.
        if ((req0_valid || req1_valid) && !PRESET) begin
          m_transfer   = 1'b1;
          m_write      = pick1 ? req1_write : req0_write;
          m_addr       = pick1 ? req1_addr  : req0_addr;
          m_wdata      = pick1 ? req1_wdata : req0_wdata;
          write_d      = m_write;
          addr_d       = m_addr;
          wdata_d      = m_wdata;
          grant_d      = pick1 ? 2'b10 : 2'b01;
          last_grant_d = pick1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_ready) begin
          if (grant_q[1]) begin
            rdata1_d = m_rdata;
          end else begin
            rdata0_d = m_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign req0_done  = (state_q == ST_DONE) && grant_q[0];
  assign req1_done  = (state_q == ST_DONE) && grant_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
